// File: rtl/arbitro_funcionalidades_pkg.sv
// Shared definitions for the front-panel two-user arbiter: role codes,
// priority encoding, basic-user permission mask and status display bit positions.
package arbitro_funcionalidades_pkg;

    localparam logic [2:0] ROLE_ADMIN   = 3'b101;
    localparam logic [2:0] ROLE_USER    = 3'b001;
    localparam logic [2:0] FUNC_NEUTRAL = 3'b000;

    // Bit f-1 set means the basic user may execute function f (1, 3, 4, 6).
    localparam logic [6:0] USER_FUNC_MASK = 7'b0101101;

    typedef enum logic [1:0] {
        PRIO_NONE  = 2'd0,
        PRIO_USER  = 2'd1,
        PRIO_ADMIN = 2'd2
    } prio_t;

    localparam int DISP_CONFLICT  = 0;
    localparam int DISP_WIN1      = 1;
    localparam int DISP_DENIED0   = 2;
    localparam int DISP_DENIED1   = 3;
    localparam int DISP_EXEC0     = 4;
    localparam int DISP_EXEC1     = 5;

    function automatic prio_t priority_of(
        input logic [2:0] code,
        input logic [2:0] admin_code,
        input logic [2:0] user_code
    );
        if (code == admin_code)
            return PRIO_ADMIN;
        else if (code == user_code)
            return PRIO_USER;
        else
            return PRIO_NONE;
    endfunction

endpackage

// File: rtl/arbitro_funcionalidades_if.sv
// Panel-side bundle: the two user/function channels in, the LED and display outputs back.
interface arbitro_funcionalidades_if;
    logic [2:0] user0;
    logic [2:0] func0;
    logic [2:0] user1;
    logic [2:0] func1;
    logic [6:0] matrix;
    logic [3:0] leds;
    logic [7:0] disp;

    modport master (
        output user0, func0, user1, func1,
        input  matrix, leds, disp
    );

    modport slave (
        input  user0, func0, user1, func1,
        output matrix, leds, disp
    );
endinterface

// File: rtl/arbitro_funcionalidades_func_decoder.sv
// Per-channel combinational decode: priority, permission and the output
// contribution the channel would make if it gets to execute.
module arbitro_funcionalidades_func_decoder
    import arbitro_funcionalidades_pkg::*;
#(
    parameter logic [2:0] ADMIN_CODE = ROLE_ADMIN,
    parameter logic [2:0] USER_CODE  = ROLE_USER
) (
    input  logic [2:0] user,
    input  logic [2:0] func,
    output prio_t      prio,
    output logic       active,
    output logic       denied,
    output logic [6:0] matrix_c,
    output logic [3:0] leds_c
);

    logic permitted;
    logic requested;

    always_comb begin
        prio      = priority_of(user, ADMIN_CODE, USER_CODE);
        requested = (func != FUNC_NEUTRAL);
        permitted = 1'b0;
        matrix_c  = 7'd0;
        leds_c    = 4'd0;

        if (requested) begin
            case (prio)
                PRIO_ADMIN: permitted = 1'b1;
                PRIO_USER:  permitted = USER_FUNC_MASK[func - 3'd1];
                default:    permitted = 1'b0;
            endcase
        end

        active = requested && permitted;
        denied = requested && !permitted;

        if (active && prio == PRIO_ADMIN)
            matrix_c = 7'd1 << (func - 3'd1);

        // leds order is {LED6, LED4, LED3, LED1}
        if (active && prio == PRIO_USER) begin
            case (func)
                3'd1:    leds_c = 4'b0001;
                3'd3:    leds_c = 4'b0010;
                3'd4:    leds_c = 4'b0100;
                3'd6:    leds_c = 4'b1000;
                default: leds_c = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/arbitro_funcionalidades.sv
// Two-user panel arbiter: decodes both channels, resolves same-function
// conflicts by priority (channel 0 on ties) and registers the merged outputs.
module arbitro_funcionalidades
    import arbitro_funcionalidades_pkg::*;
#(
    parameter logic [2:0] ADMIN_CODE = ROLE_ADMIN,
    parameter logic [2:0] USER_CODE  = ROLE_USER
) (
    input  logic                      clk,
    input  logic                      rst,
    arbitro_funcionalidades_if.slave  bus
);

    logic [2:0] user_arr   [2];
    logic [2:0] func_arr   [2];
    prio_t      prio_arr   [2];
    logic       active_arr [2];
    logic       denied_arr [2];
    logic [6:0] matrix_arr [2];
    logic [3:0] leds_arr   [2];

    assign user_arr[0] = bus.user0;
    assign func_arr[0] = bus.func0;
    assign user_arr[1] = bus.user1;
    assign func_arr[1] = bus.func1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            arbitro_funcionalidades_func_decoder #(
                .ADMIN_CODE (ADMIN_CODE),
                .USER_CODE  (USER_CODE)
            ) u_dec (
                .user     (user_arr[gi]),
                .func     (func_arr[gi]),
                .prio     (prio_arr[gi]),
                .active   (active_arr[gi]),
                .denied   (denied_arr[gi]),
                .matrix_c (matrix_arr[gi]),
                .leds_c   (leds_arr[gi])
            );
        end
    endgenerate

    logic       conflict;
    logic       win1;
    logic       exec0;
    logic       exec1;
    logic [6:0] matrix_next, matrix_reg;
    logic [3:0] leds_next,   leds_reg;
    logic [7:0] disp_next,   disp_reg;

    always_comb begin
        conflict = active_arr[0] && active_arr[1] && (func_arr[0] == func_arr[1]);
        // Channel 1 only takes a conflict with strictly higher priority.
        win1     = conflict && (prio_arr[1] > prio_arr[0]);
        exec0    = active_arr[0] && !win1;
        exec1    = active_arr[1] && !(conflict && !win1);

        matrix_next = (exec0 ? matrix_arr[0] : 7'd0) | (exec1 ? matrix_arr[1] : 7'd0);
        leds_next   = (exec0 ? leds_arr[0]   : 4'd0) | (exec1 ? leds_arr[1]   : 4'd0);

        disp_next                = 8'd0;
        disp_next[DISP_CONFLICT] = conflict;
        disp_next[DISP_WIN1]     = win1;
        disp_next[DISP_DENIED0]  = denied_arr[0];
        disp_next[DISP_DENIED1]  = denied_arr[1];
        disp_next[DISP_EXEC0]    = exec0;
        disp_next[DISP_EXEC1]    = exec1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_reg <= 7'd0;
            leds_reg   <= 4'd0;
            disp_reg   <= 8'd0;
        end else begin
            matrix_reg <= matrix_next;
            leds_reg   <= leds_next;
            disp_reg   <= disp_next;
        end
    end

    assign bus.matrix = matrix_reg;
    assign bus.leds   = leds_reg;
    assign bus.disp   = disp_reg;

endmodule

// File: tb/tb_arbitro_funcionalidades.sv
// Scoreboard bench for the panel arbiter: directed panel scenarios then random
// traffic, expected outputs computed from the arbitration rules.
module tb_arbitro_funcionalidades;

    typedef struct packed {
        logic [6:0] m;
        logic [3:0] l;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;
    exp_t q[$];

    arbitro_funcionalidades_if bus ();

    arbitro_funcionalidades dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int prio_of(input logic [2:0] u);
        if (u == 3'b101) return 2;
        if (u == 3'b001) return 1;
        return 0;
    endfunction

    function automatic bit allowed(input logic [2:0] u, input logic [2:0] f);
        int p;
        p = prio_of(u);
        if (f == 3'd0) return 0;
        if (p == 2) return 1;
        if (p == 1) return (f == 3'd1 || f == 3'd3 || f == 3'd4 || f == 3'd6);
        return 0;
    endfunction

    function automatic exp_t model(input logic [2:0] u0, input logic [2:0] f0,
                                   input logic [2:0] u1, input logic [2:0] f1);
        exp_t e;
        bit a0, a1, c, w1, x0, x1;
        e  = '0;
        a0 = allowed(u0, f0);
        a1 = allowed(u1, f1);
        c  = a0 && a1 && (f0 == f1);
        w1 = c && (prio_of(u1) > prio_of(u0));
        x0 = a0 && !(c && w1);
        x1 = a1 && !(c && !w1);
        if (x0 && prio_of(u0) == 2) e.m[f0 - 1] = 1'b1;
        if (x1 && prio_of(u1) == 2) e.m[f1 - 1] = 1'b1;
        if (x0 && prio_of(u0) == 1) e.l = e.l | (f0 == 1 ? 4'b0001 : f0 == 3 ? 4'b0010 : f0 == 4 ? 4'b0100 : 4'b1000);
        if (x1 && prio_of(u1) == 1) e.l = e.l | (f1 == 1 ? 4'b0001 : f1 == 3 ? 4'b0010 : f1 == 4 ? 4'b0100 : 4'b1000);
        e.d[0] = c;
        e.d[1] = w1;
        e.d[2] = (f0 != 0) && !a0;
        e.d[3] = (f1 != 0) && !a1;
        e.d[4] = x0;
        e.d[5] = x1;
        return e;
    endfunction

    task automatic drive(input logic r, input logic [2:0] u0, input logic [2:0] f0,
                         input logic [2:0] u1, input logic [2:0] f1);
        @(negedge clk);
        rst       = r;
        bus.user0 = u0;
        bus.func0 = f0;
        bus.user1 = u1;
        bus.func1 = f1;
        q.push_back(r ? exp_t'('0) : model(u0, f0, u1, f1));
    endtask

    // Monitor: every edge produces a result; compare it against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                txn++;
                if (bus.matrix !== e.m || bus.leds !== e.l || bus.disp !== e.d) begin
                    errors++;
                    $display("FAIL txn%0d outputs: got m=%b l=%b d=%b expected m=%b l=%b d=%b",
                             txn, bus.matrix, bus.leds, bus.disp, e.m, e.l, e.d);
                end else begin
                    $display("txn %0d ok m=%b l=%b d=%b", txn, bus.matrix, bus.leds, bus.disp);
                end
            end
        end
    end

    initial begin
        logic [2:0] u0, f0, u1, f1;
        logic       r;
        bus.user0 = 3'd0;
        bus.func0 = 3'd0;
        bus.user1 = 3'd0;
        bus.func1 = 3'd0;

        drive(1'b1, 3'b101, 3'b001, 3'b001, 3'b001);
        drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        drive(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

        drive(1'b0, 3'b101, 3'b001, 3'b001, 3'b001);
        drive(1'b0, 3'b101, 3'b010, 3'b001, 3'b001);
        drive(1'b0, 3'b101, 3'b000, 3'b001, 3'b011);
        drive(1'b0, 3'b001, 3'b100, 3'b001, 3'b100);
        drive(1'b0, 3'b001, 3'b010, 3'b110, 3'b101);
        drive(1'b0, 3'b001, 3'b110, 3'b101, 3'b110);
        drive(1'b0, 3'b101, 3'b111, 3'b101, 3'b111);
        drive(1'b0, 3'b101, 3'b010, 3'b001, 3'b001);
        drive(1'b1, 3'b101, 3'b010, 3'b001, 3'b001);
        drive(1'b0, 3'b101, 3'b010, 3'b001, 3'b001);
        drive(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

        for (int i = 0; i < 250; i++) begin
            r  = ($urandom_range(0, 24) == 0);
            u0 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'b101 : 3'b001);
            u1 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'b101 : 3'b001);
            f0 = 3'($urandom);
            f1 = ($urandom_range(0, 2) == 0) ? f0 : 3'($urandom);
            drive(r, u0, f0, u1, f1);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
